// File: rtl/anycore_arb_pkg.sv
// Shared widths, FSM state encodings, source-select encodings and the
// store-buffer entry layout for the L1.5 request arbiter.
package anycore_arb_pkg;

  // Widths shared with the rest of the core (CommonConfig.h).
  localparam int ICACHE_BLOCK_ADDR_BITS = 26;
  localparam int DCACHE_BLOCK_ADDR_BITS = 26;
  localparam int DCACHE_ST_ADDR_BITS    = 29;
  localparam int SIZE_DATA              = 64;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE    = 2'd1,
    ARB_WAIT_ACK = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_IFILL = 2'd1,
    SRC_STORE = 2'd2,
    SRC_LOAD  = 2'd3
  } arb_src_e;

  typedef struct packed {
    logic [DCACHE_ST_ADDR_BITS-1:0] addr;
    logic [SIZE_DATA-1:0]           data;
    logic [2:0]                     size;
  } st_entry_t;

endpackage

// File: rtl/anycore_st_fifo.sv
// Store buffer: power-of-two FIFO with wrap-around pointers and an
// occupancy count one bit wider than the pointers. A push into a full
// FIFO succeeds only if a pop frees a slot in the same cycle; otherwise
// the entry is dropped and reported on drop.
module anycore_st_fifo
  import anycore_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  st_entry_t        push_entry,
  input  logic             pop,
  output st_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             drop
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  st_entry_t        mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the array is deliberately not reset; count/empty gate every read,
  // so stale contents are never observed and no reset fan-out is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/anycore_mem_req_arb.sv
// Arbiter in front of the L1.5 request decoder. Buffers one ifill, one
// load and a store FIFO, and issues at most one request at a time as a
// single-cycle pulse, then waits for l15_transducer_ack. Priority is
// ifill > store head > load; a load never overtakes a buffered store.
module anycore_mem_req_arb
  import anycore_arb_pkg::*;
#(
  parameter int ST_FIFO_DEPTH = 4,
  parameter int ST_PTR_W      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ICACHE_BLOCK_ADDR_BITS-1:0] ic2mem_reqaddr,
  input  logic                              ic2mem_reqvalid,
  input  logic [DCACHE_BLOCK_ADDR_BITS-1:0] dc2mem_ldaddr,
  input  logic                              dc2mem_ldvalid,
  input  logic [DCACHE_ST_ADDR_BITS-1:0]    dc2mem_staddr,
  input  logic [SIZE_DATA-1:0]              dc2mem_stdata,
  input  logic [2:0]                        dc2mem_stsize,
  input  logic                              dc2mem_stvalid,
  input  logic                              l15_transducer_ack,
  output logic [ICACHE_BLOCK_ADDR_BITS-1:0] arb_ic_reqaddr,
  output logic                              arb_ic_reqvalid,
  output logic [DCACHE_BLOCK_ADDR_BITS-1:0] arb_dc_ldaddr,
  output logic                              arb_dc_ldvalid,
  output logic [DCACHE_ST_ADDR_BITS-1:0]    arb_dc_staddr,
  output logic [SIZE_DATA-1:0]              arb_dc_stdata,
  output logic [2:0]                        arb_dc_stsize,
  output logic                              arb_dc_stvalid,
  output logic                              arb_st_full,
  output logic                              arb_busy,
  output logic                              arb_overflow
);

  arb_state_e state_q, state_d;
  arb_src_e   sel_q, sel_d;

  logic                              ic_pend;
  logic [ICACHE_BLOCK_ADDR_BITS-1:0] ic_addr;
  logic                              ld_pend;
  logic [DCACHE_BLOCK_ADDR_BITS-1:0] ld_addr;
  logic                              overflow_q;

  // Last issued fields, shown while no request is being pulsed.
  logic [ICACHE_BLOCK_ADDR_BITS-1:0] ic_last;
  logic [DCACHE_BLOCK_ADDR_BITS-1:0] ld_last;
  st_entry_t                         st_last;

  st_entry_t          st_head;
  st_entry_t          st_in;
  logic               st_full;
  logic               st_empty;
  logic [ST_PTR_W:0]  st_count;
  logic               st_drop;

  logic outstanding;
  logic ack_taken;
  logic ic_clr;
  logic ld_clr;
  logic st_pop;
  logic ic_drop;
  logic ld_drop;
  logic ic_avail;
  logic st_avail;
  logic ld_avail;

  assign st_in = '{addr: dc2mem_staddr, data: dc2mem_stdata, size: dc2mem_stsize};

  anycore_st_fifo #(
    .DEPTH (ST_FIFO_DEPTH),
    .PTR_W (ST_PTR_W)
  ) u_st_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (dc2mem_stvalid),
    .push_entry (st_in),
    .pop        (st_pop),
    .head       (st_head),
    .full       (st_full),
    .empty      (st_empty),
    .count      (st_count),
    .drop       (st_drop)
  );

  // An ack retires the latched source in ISSUE as well as in WAIT_ACK.
  assign outstanding = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT_ACK);
  assign ack_taken   = l15_transducer_ack & outstanding;
  assign ic_clr      = ack_taken & (sel_q == SRC_IFILL);
  assign st_pop      = ack_taken & (sel_q == SRC_STORE);
  assign ld_clr      = ack_taken & (sel_q == SRC_LOAD);

  // A new request is accepted whenever its slot is free or being freed now.
  assign ic_drop = ic2mem_reqvalid & ic_pend & ~ic_clr;
  assign ld_drop = dc2mem_ldvalid & ld_pend & ~ld_clr;

  // Arrivals count as pending in IDLE so an idle arbiter issues next cycle.
  assign ic_avail = ic_pend | ic2mem_reqvalid;
  assign st_avail = ~st_empty | dc2mem_stvalid;
  assign ld_avail = ld_pend | dc2mem_ldvalid;

  // Ifill and load holding registers plus the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_pend    <= 1'b0;
      ic_addr    <= '0;
      ld_pend    <= 1'b0;
      ld_addr    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (ic2mem_reqvalid && (!ic_pend || ic_clr)) begin
        ic_pend <= 1'b1;
        ic_addr <= ic2mem_reqaddr;
      end else if (ic_clr) begin
        ic_pend <= 1'b0;
      end
      if (dc2mem_ldvalid && (!ld_pend || ld_clr)) begin
        ld_pend <= 1'b1;
        ld_addr <= dc2mem_ldaddr;
      end else if (ld_clr) begin
        ld_pend <= 1'b0;
      end
      if (ic_drop || ld_drop || st_drop) overflow_q <= 1'b1;
    end
  end

  // FSM state register and latched source selection.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      sel_q   <= SRC_NONE;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // FSM next state and priority selection (ifill > store > load).
  // NOTE: defaults at the top keep this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ARB_IDLE: begin
        if (ic_avail) begin
          state_d = ARB_ISSUE;
          sel_d   = SRC_IFILL;
        end else if (st_avail) begin
          state_d = ARB_ISSUE;
          sel_d   = SRC_STORE;
        end else if (ld_avail) begin
          state_d = ARB_ISSUE;
          sel_d   = SRC_LOAD;
        end
      end
      ARB_ISSUE:    state_d = l15_transducer_ack ? ARB_IDLE : ARB_WAIT_ACK;
      ARB_WAIT_ACK: if (l15_transducer_ack) state_d = ARB_IDLE;
      default:      state_d = ARB_IDLE;
    endcase
  end

  // Capture the issued fields so outputs hold them once the pulse ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_last <= '0;
      ld_last <= '0;
      st_last <= '0;
    end else if (state_q == ARB_ISSUE) begin
      case (sel_q)
        SRC_IFILL: ic_last <= ic_addr;
        SRC_STORE: st_last <= st_head;
        SRC_LOAD:  ld_last <= ld_addr;
        default:   ;
      endcase
    end
  end

  // FSM outputs: one valid pulse in ISSUE, held fields otherwise.
  always_comb begin
    arb_ic_reqvalid = 1'b0;
    arb_dc_ldvalid  = 1'b0;
    arb_dc_stvalid  = 1'b0;
    arb_ic_reqaddr  = ic_last;
    arb_dc_ldaddr   = ld_last;
    arb_dc_staddr   = st_last.addr;
    arb_dc_stdata   = st_last.data;
    arb_dc_stsize   = st_last.size;
    if (state_q == ARB_ISSUE) begin
      case (sel_q)
        SRC_IFILL: begin
          arb_ic_reqvalid = 1'b1;
          arb_ic_reqaddr  = ic_addr;
        end
        SRC_STORE: begin
          arb_dc_stvalid = 1'b1;
          arb_dc_staddr  = st_head.addr;
          arb_dc_stdata  = st_head.data;
          arb_dc_stsize  = st_head.size;
        end
        SRC_LOAD: begin
          arb_dc_ldvalid = 1'b1;
          arb_dc_ldaddr  = ld_addr;
        end
        default: ;
      endcase
    end
  end

  assign arb_st_full  = st_full;
  assign arb_overflow = overflow_q;
  assign arb_busy     = (state_q != ARB_IDLE) | ic_pend | ld_pend | (st_count != '0);

endmodule

// File: tb/tb_anycore_mem_req_arb.sv
// Self-checking bench for anycore_mem_req_arb. Expected request pulses are
// queued when stimulus is driven and compared by a monitor whenever the
// arbiter pulses a valid; scenario tasks check flags inline.
module tb_anycore_mem_req_arb;
  import anycore_arb_pkg::*;

  logic                              clk = 1'b0;
  logic                              rst = 1'b1;
  logic [ICACHE_BLOCK_ADDR_BITS-1:0] ic2mem_reqaddr = '0;
  logic                              ic2mem_reqvalid = 1'b0;
  logic [DCACHE_BLOCK_ADDR_BITS-1:0] dc2mem_ldaddr = '0;
  logic                              dc2mem_ldvalid = 1'b0;
  logic [DCACHE_ST_ADDR_BITS-1:0]    dc2mem_staddr = '0;
  logic [SIZE_DATA-1:0]              dc2mem_stdata = '0;
  logic [2:0]                        dc2mem_stsize = '0;
  logic                              dc2mem_stvalid = 1'b0;
  logic                              l15_transducer_ack = 1'b0;
  logic [ICACHE_BLOCK_ADDR_BITS-1:0] arb_ic_reqaddr;
  logic                              arb_ic_reqvalid;
  logic [DCACHE_BLOCK_ADDR_BITS-1:0] arb_dc_ldaddr;
  logic                              arb_dc_ldvalid;
  logic [DCACHE_ST_ADDR_BITS-1:0]    arb_dc_staddr;
  logic [SIZE_DATA-1:0]              arb_dc_stdata;
  logic [2:0]                        arb_dc_stsize;
  logic                              arb_dc_stvalid;
  logic                              arb_st_full;
  logic                              arb_busy;
  logic                              arb_overflow;

  anycore_mem_req_arb #(.ST_FIFO_DEPTH(4), .ST_PTR_W(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .ic2mem_reqaddr     (ic2mem_reqaddr),
    .ic2mem_reqvalid    (ic2mem_reqvalid),
    .dc2mem_ldaddr      (dc2mem_ldaddr),
    .dc2mem_ldvalid     (dc2mem_ldvalid),
    .dc2mem_staddr      (dc2mem_staddr),
    .dc2mem_stdata      (dc2mem_stdata),
    .dc2mem_stsize      (dc2mem_stsize),
    .dc2mem_stvalid     (dc2mem_stvalid),
    .l15_transducer_ack (l15_transducer_ack),
    .arb_ic_reqaddr     (arb_ic_reqaddr),
    .arb_ic_reqvalid    (arb_ic_reqvalid),
    .arb_dc_ldaddr      (arb_dc_ldaddr),
    .arb_dc_ldvalid     (arb_dc_ldvalid),
    .arb_dc_staddr      (arb_dc_staddr),
    .arb_dc_stdata      (arb_dc_stdata),
    .arb_dc_stsize      (arb_dc_stsize),
    .arb_dc_stvalid     (arb_dc_stvalid),
    .arb_st_full        (arb_st_full),
    .arb_busy           (arb_busy),
    .arb_overflow       (arb_overflow)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] K_IC = 2'd1;
  localparam logic [1:0] K_ST = 2'd2;
  localparam logic [1:0] K_LD = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [63:0] data;
    logic [2:0]  size;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [63:0] st_data(input logic [31:0] a);
    return 64'hA5A5_0000_0000_0000 | 64'(a);
  endfunction

  function automatic logic [2:0] st_size(input logic [31:0] a);
    return 3'(a + 32'd3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_req(input logic [1:0] k, input logic [31:0] a);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = (k == K_ST) ? st_data(a) : 64'd0;
    e.size = (k == K_ST) ? st_size(a) : 3'd0;
    sb.push_back(e);
  endtask

  task automatic drive_store(input logic [31:0] a);
    dc2mem_staddr  = DCACHE_ST_ADDR_BITS'(a);
    dc2mem_stdata  = st_data(a);
    dc2mem_stsize  = st_size(a);
    dc2mem_stvalid = 1'b1;
  endtask

  task automatic clear_inputs();
    ic2mem_reqvalid    = 1'b0;
    dc2mem_ldvalid     = 1'b0;
    dc2mem_stvalid     = 1'b0;
    l15_transducer_ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: every valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    int   nv;
    exp_t e;
    logic [1:0]  ok;
    logic [31:0] oa;
    logic [63:0] od;
    logic [2:0]  os;
    if (!rst) begin
      nv = int'(arb_ic_reqvalid) + int'(arb_dc_ldvalid) + int'(arb_dc_stvalid);
      if (nv != 0) begin
        vectors++;
        ok = arb_ic_reqvalid ? K_IC : (arb_dc_stvalid ? K_ST : K_LD);
        oa = arb_ic_reqvalid ? 32'(arb_ic_reqaddr) :
             (arb_dc_stvalid ? 32'(arb_dc_staddr) : 32'(arb_dc_ldaddr));
        od = arb_dc_stvalid ? arb_dc_stdata : 64'd0;
        os = arb_dc_stvalid ? arb_dc_stsize : 3'd0;
        if (nv > 1) begin
          miscompares++;
          $display("FAIL onehot_valid: %0d valids high, required 1", nv);
        end else if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse: kind %0d addr 0x%0h, required no pulse", ok, oa);
        end else begin
          e = sb.pop_front();
          if (ok !== e.kind || oa !== e.addr || od !== e.data || os !== e.size)
          begin
            miscompares++;
            $display("FAIL pulse: got kind %0d addr 0x%0h data 0x%0h size %0d, required kind %0d addr 0x%0h data 0x%0h size %0d",
                     ok, oa, od, os, e.kind, e.addr, e.data, e.size);
          end
        end
      end
    end
  end

  // Wait (bounded) for the next pulse, then ack it one cycle later.
  task automatic ack_next(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (arb_ic_reqvalid || arb_dc_ldvalid || arb_dc_stvalid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s: no request pulse within 20 cycles, required one", name);
    end else begin
      step();
      l15_transducer_ack = 1'b1;
      step();
      l15_transducer_ack = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({arb_ic_reqvalid, arb_dc_ldvalid, arb_dc_stvalid} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s_valids: got %b, required 000", name,
               {arb_ic_reqvalid, arb_dc_ldvalid, arb_dc_stvalid});
    end
    vectors++;
    if ({arb_ic_reqaddr, arb_dc_ldaddr, arb_dc_staddr, arb_dc_stdata, arb_dc_stsize} !== '0) begin
      miscompares++;
      $display("FAIL %s_fields: got ic 0x%0h ld 0x%0h st 0x%0h data 0x%0h size %0d, required all 0",
               name, arb_ic_reqaddr, arb_dc_ldaddr, arb_dc_staddr, arb_dc_stdata, arb_dc_stsize);
    end
    vectors++;
    if ({arb_st_full, arb_busy, arb_overflow} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s_flags: got full/busy/ovf %b, required 000", name,
               {arb_st_full, arb_busy, arb_overflow});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    check_idle_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_ifill_latency();
    do_reset();
    exp_req(K_IC, 32'h1234);
    ic2mem_reqaddr  = 26'h1234;
    ic2mem_reqvalid = 1'b1;
    step();
    ic2mem_reqvalid = 1'b0;
    vectors++;
    if (arb_ic_reqvalid !== 1'b1 || arb_ic_reqaddr !== 26'h1234) begin
      miscompares++;
      $display("FAIL ifill_latency: valid %b addr 0x%0h, required 1 0x1234",
               arb_ic_reqvalid, arb_ic_reqaddr);
    end
    step();
    vectors++;
    if (arb_ic_reqvalid !== 1'b0 || arb_ic_reqaddr !== 26'h1234) begin
      miscompares++;
      $display("FAIL ifill_hold: valid %b addr 0x%0h, required 0 0x1234",
               arb_ic_reqvalid, arb_ic_reqaddr);
    end
    step();
    step();
    l15_transducer_ack = 1'b1;
    step();
    l15_transducer_ack = 1'b0;
    vectors++;
    if (arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ifill_busy_after_ack: got %b, required 0", arb_busy);
    end
  endtask

  task automatic test_store_fill();
    do_reset();
    for (int i = 0; i < 4; i++) exp_req(K_ST, 32'h10 + 32'(i));
    for (int i = 0; i < 5; i++) begin
      drive_store(32'h10 + 32'(i));
      step();
      if (i == 3) begin
        vectors++;
        if (arb_st_full !== 1'b1 || arb_overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL st_full_after_4: full %b ovf %b, required 1 0",
                   arb_st_full, arb_overflow);
        end
      end
    end
    dc2mem_stvalid = 1'b0;
    vectors++;
    if (arb_overflow !== 1'b1 || arb_st_full !== 1'b1) begin
      miscompares++;
      $display("FAIL st_overflow: ovf %b full %b, required 1 1", arb_overflow, arb_st_full);
    end
    l15_transducer_ack = 1'b1;
    step();
    l15_transducer_ack = 1'b0;
    vectors++;
    if (arb_st_full !== 1'b0) begin
      miscompares++;
      $display("FAIL st_full_after_pop: got %b, required 0", arb_st_full);
    end
    for (int i = 0; i < 3; i++) ack_next("st_drain");
    vectors++;
    if (arb_busy !== 1'b0 || arb_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL st_drained: busy %b ovf %b, required 0 1", arb_busy, arb_overflow);
    end
  endtask

  task automatic test_ifill_vs_store();
    do_reset();
    exp_req(K_IC, 32'h2000);
    exp_req(K_ST, 32'h20);
    ic2mem_reqaddr  = 26'h2000;
    ic2mem_reqvalid = 1'b1;
    drive_store(32'h20);
    step();
    clear_inputs();
    vectors++;
    if (arb_ic_reqvalid !== 1'b1 || arb_dc_stvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL ifill_first: ic %b st %b, required 1 0", arb_ic_reqvalid, arb_dc_stvalid);
    end
    ack_next("prio_ifill");
    ack_next("prio_store");
  endtask

  task automatic test_load_after_store();
    do_reset();
    exp_req(K_ST, 32'h30);
    exp_req(K_LD, 32'h40);
    drive_store(32'h30);
    step();
    dc2mem_stvalid = 1'b0;
    dc2mem_ldaddr  = 26'h40;
    dc2mem_ldvalid = 1'b1;
    step();
    dc2mem_ldvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (arb_dc_ldvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL load_bypass: ld valid %b before store ack, required 0", arb_dc_ldvalid);
      end
      step();
    end
    l15_transducer_ack = 1'b1;
    step();
    l15_transducer_ack = 1'b0;
    ack_next("load_after_store");
    vectors++;
    if (arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_busy: got %b, required 0", arb_busy);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 5; i++) exp_req(K_ST, 32'h50 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h50 + 32'(i));
      step();
    end
    drive_store(32'h54);
    l15_transducer_ack = 1'b1;
    step();
    clear_inputs();
    vectors++;
    if (arb_st_full !== 1'b1 || arb_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_push_pop: full %b ovf %b, required 1 0", arb_st_full, arb_overflow);
    end
    for (int i = 0; i < 4; i++) ack_next("full_drain");
    vectors++;
    if (arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_drain_busy: got %b, required 0", arb_busy);
    end
  endtask

  task automatic test_drop();
    do_reset();
    exp_req(K_IC, 32'h100);
    ic2mem_reqaddr  = 26'h100;
    ic2mem_reqvalid = 1'b1;
    step();
    ic2mem_reqaddr  = 26'h101;
    step();
    ic2mem_reqvalid = 1'b0;
    vectors++;
    if (arb_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ifill_drop: ovf %b, required 1", arb_overflow);
    end
    l15_transducer_ack = 1'b1;
    step();
    l15_transducer_ack = 1'b0;
    step();
    vectors++;
    if (arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ifill_drop_busy: got %b, required 0", arb_busy);
    end
  endtask

  task automatic test_ack_in_issue();
    do_reset();
    exp_req(K_IC, 32'h3333);
    ic2mem_reqaddr  = 26'h3333;
    ic2mem_reqvalid = 1'b1;
    step();
    ic2mem_reqvalid    = 1'b0;
    l15_transducer_ack = 1'b1;
    step();
    l15_transducer_ack = 1'b0;
    vectors++;
    if (arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_in_issue: busy %b, required 0", arb_busy);
    end
    l15_transducer_ack = 1'b1;
    step();
    l15_transducer_ack = 1'b0;
    step();
    vectors++;
    if (arb_busy !== 1'b0 || arb_ic_reqvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_in_idle: busy %b ic valid %b, required 0 0", arb_busy, arb_ic_reqvalid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    exp_req(K_ST, 32'h60);
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h60 + 32'(i));
      step();
    end
    dc2mem_stvalid = 1'b0;
    rst = 1'b1;
    step();
    check_idle_outputs("reset_mid");
    rst = 1'b0;
    l15_transducer_ack = 1'b1;
    step();
    l15_transducer_ack = 1'b0;
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_busy: got %b, required 0", arb_busy);
    end
  endtask

  initial begin
    test_reset();
    test_ifill_latency();
    test_store_fill();
    test_ifill_vs_store();
    test_load_after_store();
    test_full_push_pop();
    test_drop();
    test_ack_in_issue();
    test_reset_mid();
    step();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: %0d expected pulses never seen, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
